// File: rtl/dpram_sync_param.sv
// Single-clock true dual-port RAM with selectable read latency, defined
// read-during-write behaviour, same-address write arbitration (port A wins)
// with sticky error/saturating counter, and an optional post-reset zero fill.
module dpram_sync_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 15,
    parameter int RD_LAT     = 2,
    parameter int WR_MODE    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic              a_wen,
    input  logic              a_ren,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_dvalid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    input  logic              b_wen,
    input  logic              b_ren,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_dvalid,
    output logic              init_busy,
    output logic              coll_err,
    output logic [15:0]       coll_cnt,
    input  logic              coll_clr
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         clr_addr_q;
    logic [DATA_W-1:0]         mem [DEPTH];

    // Port 0 = A, port 1 = B
    logic [1:0][ADDR_W-1:0]    addr;
    logic [1:0][DATA_W-1:0]    din;
    logic [1:0][DATA_W-1:0]    rdata;
    logic [1:0]                we, rd;
    logic                      run, coll;

    logic [1:0][DATA_W-1:0]    s1_q;
    logic [1:0]                s1_vld_q;
    logic [1:0][DATA_W-1:0]    dout_p;
    logic [1:0]                dvalid_p;

    logic                      coll_err_q;
    logic [15:0]               coll_cnt_q;

    assign addr = {b_addr, a_addr};
    assign din  = {b_din, a_din};
    assign run  = (state_q == S_RUN);
    // B's write is dropped on a same-address collision so A's data lands
    assign coll = run & a_wen & b_wen & (a_addr == b_addr);
    assign we   = {run & b_wen & ~coll, run & a_wen};
    assign rd   = {run & b_ren, run & a_ren};

    // State register: start in CLEAR when a zero fill is wanted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= (CLR_ON_RST != 0) ? S_CLEAR : S_RUN;
        else        state_q <= state_d;
    end

    // Next state: leave CLEAR once the last address has been zeroed
    always_comb begin
        state_d = state_q;
        if (state_q == S_CLEAR && clr_addr_q == '1) state_d = S_RUN;
    end

    // FSM outputs
    always_comb begin
        init_busy = (state_q == S_CLEAR);
    end

    // Clear address walks the array one word per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   clr_addr_q <= '0;
        else if (!run) clr_addr_q <= clr_addr_q + 1'b1;
    end

    // Array writes: zero fill during CLEAR, port writes during RUN
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_addr_q] <= '0;
        end else begin
            if (we[0]) mem[addr[0]] <= din[0];
            if (we[1]) mem[addr[1]] <= din[1];
        end
    end

    // Read data: array word, or the word being written this cycle in write-first mode
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = mem[addr[p]];
            if (WR_MODE == 1) begin
                if (we[1] && addr[1] == addr[p]) rdata[p] = din[1];
                if (we[0] && addr[0] == addr[p]) rdata[p] = din[0];
            end
        end
    end

    // First read stage; data only updates on a read so DOUT holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s1_vld_q <= '0;
        end else begin
            s1_vld_q <= rd;
            for (int p = 0; p < 2; p++)
                if (rd[p]) s1_q[p] <= rdata[p];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [1:0][DATA_W-1:0] s2_q;
            logic [1:0]             s2_vld_q;

            // Extra output register stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_q     <= '0;
                    s2_vld_q <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    for (int p = 0; p < 2; p++)
                        if (s1_vld_q[p]) s2_q[p] <= s1_q[p];
                end
            end

            assign dout_p   = s2_q;
            assign dvalid_p = s2_vld_q;
        end else begin : g_lat1
            assign dout_p   = s1_q;
            assign dvalid_p = s1_vld_q;
        end
    endgenerate

    assign a_dout   = dout_p[0];
    assign b_dout   = dout_p[1];
    assign a_dvalid = dvalid_p[0];
    assign b_dvalid = dvalid_p[1];

    // Collision tracking; a clear wins over a same-cycle collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_err_q <= 1'b0;
            coll_cnt_q <= '0;
        end else if (coll_clr) begin
            coll_err_q <= 1'b0;
            coll_cnt_q <= '0;
        end else if (coll) begin
            coll_err_q <= 1'b1;
            if (coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    assign coll_err = coll_err_q;
    assign coll_cnt = coll_cnt_q;

endmodule
